// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution window accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: product/accumulator/pixel widths, fixed-point typedefs, sign-extension helper.
package conv_pkg;

   localparam int PROD_W  = 26;   // sfix26_En18 multiplier product
   localparam int FRAC    = 18;   // fractional bits of product and sum
   localparam int OUT_W   = 8;    // ufix8_En0 output pixel
   localparam int PIX_MAX = 255;
   // Sized for the largest window (16 taps), so any legal TAPS sums without wrap.
   localparam int ACC_W   = PROD_W + 4;

   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic        [OUT_W-1:0]  pix_t;

   function automatic acc_t sext(input prod_t p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/conv_window_accumulator_if.sv
// Bundle between the product source and the window accumulator.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer of PixelValid must take every pulse.
// Signals: ProductPort/ProductValid/Clear in, PixelOut/PixelValid/SumOut/SatFlag/TapCount out.
interface conv_window_accumulator_if;
   import conv_pkg::*;

   prod_t      ProductPort;
   logic       ProductValid;
   logic       Clear;
   pix_t       PixelOut;
   logic       PixelValid;
   acc_t       SumOut;
   logic       SatFlag;
   logic [3:0] TapCount;

   modport master (
      output ProductPort, ProductValid, Clear,
      input  PixelOut, PixelValid, SumOut, SatFlag, TapCount
   );

   modport slave (
      input  ProductPort, ProductValid, Clear,
      output PixelOut, PixelValid, SumOut, SatFlag, TapCount
   );

endinterface

// File: rtl/round_sat_u8.sv
// Round a signed En18 window sum half-up to an integer and clamp it to an unsigned pixel.
// Latency: 0 (combinational); the caller registers the result.
// Backpressure: n/a.
// Ports: Sum (sfix30_En18) in; Pixel (ufix8) out; Sat out, high when the clamp engaged.
module round_sat_u8
   import conv_pkg::*;
(
   input  acc_t Sum,
   output pix_t Pixel,
   output logic Sat
);

   // One extra bit so adding the half-LSB bias cannot wrap near the positive limit.
   localparam int RW = ACC_W + 1;
   localparam logic signed [RW-1:0] Half    = RW'(2 ** (FRAC - 1));
   localparam logic signed [RW-1:0] PixMaxW = RW'(PIX_MAX);

   logic signed [RW-1:0] biased;
   logic signed [RW-1:0] rounded;

   always_comb begin
      biased  = {Sum[ACC_W-1], Sum} + Half;
      rounded = biased >>> FRAC;
      Pixel   = rounded[OUT_W-1:0];
      Sat     = 1'b0;
      if (rounded[RW-1]) begin
         Pixel = '0;
         Sat   = 1'b1;
      end else if (rounded > PixMaxW) begin
         Pixel = pix_t'(PIX_MAX);
         Sat   = 1'b1;
      end
   end

endmodule

// File: rtl/conv_window_accumulator.sv
// Sum TAPS valid products per kernel window, then emit a rounded, saturated pixel plus the raw sum.
// Latency: 1 cycle from the last product of a window to the PixelValid pulse.
// Backpressure: none; ProductValid=0 is a bubble that holds state, downstream takes every pulse.
// Ports: clk, GlobalReset (sync, active-high), bus (slave side of conv_window_accumulator_if).
module conv_window_accumulator
   import conv_pkg::*;
#(
   parameter int TAPS = 9   // legal 2..16; ACC_W in conv_pkg covers the 16-tap worst case
)(
   input  logic                       clk,
   input  logic                       GlobalReset,
   conv_window_accumulator_if.slave   bus
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t     state;
   acc_t       accReg;
   acc_t       nextSum;
   logic [3:0] tapCnt;
   pix_t       pixReg;
   acc_t       sumReg;
   logic       validReg;
   logic       satReg;
   pix_t       rsPixel;
   logic       rsSat;

   // A new window starts from zero rather than from the stale previous sum.
   always_comb begin
      nextSum = ((state == IDLE) ? acc_t'(0) : accReg) + sext(bus.ProductPort);
   end

   round_sat_u8 u_roundSat (
      .Sum   (nextSum),
      .Pixel (rsPixel),
      .Sat   (rsSat)
   );

   always_ff @(posedge clk) begin
      if (GlobalReset) begin
         state    <= IDLE;
         accReg   <= '0;
         tapCnt   <= '0;
         pixReg   <= '0;
         sumReg   <= '0;
         validReg <= 1'b0;
         satReg   <= 1'b0;
      end else begin
         validReg <= 1'b0;
         if (bus.Clear) begin
            // Abort wins over a concurrent product, including a window-end one.
            state  <= IDLE;
            tapCnt <= '0;
         end else if (bus.ProductValid) begin
            accReg <= nextSum;
            if (tapCnt == 4'(TAPS - 1)) begin
               sumReg   <= nextSum;
               pixReg   <= rsPixel;
               validReg <= 1'b1;
               satReg   <= satReg | rsSat;
               tapCnt   <= '0;
               state    <= IDLE;
            end else begin
               tapCnt <= tapCnt + 4'd1;
               state  <= ACCUM;
            end
         end
      end
   end

   assign bus.PixelOut   = pixReg;
   assign bus.PixelValid = validReg;
   assign bus.SumOut     = sumReg;
   assign bus.SatFlag    = satReg;
   assign bus.TapCount   = tapCnt;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based window model.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_window_accumulator;
   import conv_pkg::*;

   localparam int TAPS = 9;

   logic clk;
   logic GlobalReset;

   conv_window_accumulator_if ifc ();

   conv_window_accumulator #(.TAPS(TAPS)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .bus         (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nBad    = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      nChecks++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: products of the open window kept in a queue; the window is summed and
   // converted with plain integer arithmetic when it fills.
   longint mdlWin[$];
   logic   expValid;
   longint expPix, expSum;
   logic   expSat;
   int     cyc;
   int     pulseCyc[$];

   function automatic longint floorDiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   task automatic modelEdge(input logic v, input longint d, input logic c, input logic r);
      longint s, q;
      if (r) begin
         mdlWin.delete();
         expValid = 0; expPix = 0; expSum = 0; expSat = 0;
      end else begin
         expValid = 0;
         if (c) mdlWin.delete();
         else if (v) begin
            mdlWin.push_back(d);
            if (mdlWin.size() == TAPS) begin
               s = 0;
               foreach (mdlWin[i]) s += mdlWin[i];
               q = floorDiv(s + 131072, 262144);
               expSum = s;
               if (q < 0)        begin expPix = 0;   expSat = 1; end
               else if (q > 255) begin expPix = 255; expSat = 1; end
               else              expPix = q;
               expValid = 1;
               mdlWin.delete();
            end
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, then compare every output at the falling edge.
   task automatic step(input logic v, input longint d, input logic c, input logic r);
      ifc.ProductValid = v;
      ifc.ProductPort  = prod_t'(d);
      ifc.Clear        = c;
      GlobalReset      = r;
      @(posedge clk);
      modelEdge(v, longint'(prod_t'(d)), c, r);
      cyc++;
      @(negedge clk);
      chk("PixelValid", longint'(ifc.PixelValid), longint'(expValid));
      chk("TapCount",   longint'(ifc.TapCount),   longint'(mdlWin.size()));
      chk("PixelOut",   longint'(ifc.PixelOut),   expPix);
      chk("SumOut",     longint'(ifc.SumOut),     expSum);
      chk("SatFlag",    longint'(ifc.SatFlag),    longint'(expSat));
      if (ifc.PixelValid) pulseCyc.push_back(cyc);
   endtask

   task automatic window(input longint d, input int maxBubble);
      for (int i = 0; i < TAPS; i++) begin
         step(1'b1, d, 1'b0, 1'b0);
         if (i != TAPS - 1)
            for (int b = 0; b < int'($urandom_range(0, maxBubble)); b++)
               step(1'b0, longint'($urandom), 1'b0, 1'b0);
      end
   endtask

   initial begin
      prod_t p;
      ifc.ProductValid = 1'b0;
      ifc.ProductPort  = '0;
      ifc.Clear        = 1'b0;
      GlobalReset      = 1'b1;
      cyc              = 0;
      expValid = 0; expPix = 0; expSum = 0; expSat = 0;

      // Reset state
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 1234, 1'b0, 1'b1);
      chk("rst_pix", longint'(ifc.PixelOut), 0);
      chk("rst_tap", longint'(ifc.TapCount), 0);
      step(1'b0, 0, 1'b0, 1'b0);

      // 1: back-to-back window
      pulseCyc.delete();
      window(2621430, 0);
      chk("t1_sum", longint'(ifc.SumOut), 23592870);
      chk("t1_pix", longint'(ifc.PixelOut), 90);
      chk("t1_vld", longint'(ifc.PixelValid), 1);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("t1_pulses", longint'(pulseCyc.size()), 1);

      // 2: same stream with bubbles
      pulseCyc.delete();
      window(2621430, 3);
      chk("t2_sum", longint'(ifc.SumOut), 23592870);
      chk("t2_pix", longint'(ifc.PixelOut), 90);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("t2_pulses", longint'(pulseCyc.size()), 1);

      // 3: negative window clamps to 0; flag is sticky across a clean window
      window(-13107200, 0);
      chk("t3_sum", longint'(ifc.SumOut), -117964800);
      chk("t3_pix", longint'(ifc.PixelOut), 0);
      chk("t3_sat", longint'(ifc.SatFlag), 1);
      window(262144, 1);
      chk("t3_sticky", longint'(ifc.SatFlag), 1);
      chk("t3_pix2", longint'(ifc.PixelOut), 9);

      // 4: max positive products, no wrap
      step(1'b0, 0, 1'b0, 1'b1);
      chk("t4_sat0", longint'(ifc.SatFlag), 0);
      window(33554431, 0);
      chk("t4_sum", longint'(ifc.SumOut), 301989879);
      chk("t4_pix", longint'(ifc.PixelOut), 255);
      chk("t4_sat", longint'(ifc.SatFlag), 1);

      // 5: two windows with no gap
      pulseCyc.delete();
      window(262144, 0);
      chk("t5_pix_a", longint'(ifc.PixelOut), 9);
      window(524288, 0);
      chk("t5_pix_b", longint'(ifc.PixelOut), 18);
      chk("t5_pulses", longint'(pulseCyc.size()), 2);
      if (pulseCyc.size() == 2) chk("t5_spacing", longint'(pulseCyc[1] - pulseCyc[0]), 9);

      // 6: Clear after 4 taps (with a concurrent product), then a full window
      pulseCyc.delete();
      for (int i = 0; i < 4; i++) step(1'b1, 262144, 1'b0, 1'b0);
      step(1'b1, 262144, 1'b1, 1'b0);
      chk("t6_clr_tap", longint'(ifc.TapCount), 0);
      window(262144, 0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("t6_pulses", longint'(pulseCyc.size()), 1);
      chk("t6_pix", longint'(ifc.PixelOut), 9);

      // 6b: GlobalReset at tap 4
      for (int i = 0; i < 4; i++) step(1'b1, 262144, 1'b0, 1'b0);
      step(1'b1, 262144, 1'b1, 1'b1);
      chk("t6r_pix", longint'(ifc.PixelOut), 0);
      chk("t6r_sum", longint'(ifc.SumOut), 0);
      chk("t6r_tap", longint'(ifc.TapCount), 0);
      window(262144, 0);
      chk("t6r_pix2", longint'(ifc.PixelOut), 9);

      // Clear coinciding with a window-end product drops the window
      pulseCyc.delete();
      for (int i = 0; i < TAPS - 1; i++) step(1'b1, 524288, 1'b0, 1'b0);
      step(1'b1, 524288, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("clr_end_pulses", longint'(pulseCyc.size()), 0);
      chk("clr_end_pix", longint'(ifc.PixelOut), 9);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if ($urandom_range(0, 1) == 0) p = prod_t'($urandom);
         else                           p = prod_t'($urandom_range(0, 30 * 262144));
         step(sel < 70, longint'(p), sel >= 97, sel == 96);
      end

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
